// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the
// memory port plus ALU/register-file datapath.
interface multicycle_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic [6:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                alu_src;
    logic [3:0]          alu_control;
    logic                reg_write;
    logic                mem_to_reg;
    logic                illegal;
    logic [2:0]          state;
    logic [RETIRE_W-1:0] retire_count;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src,
               alu_control, reg_write, mem_to_reg, illegal, state, retire_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src,
               alu_control, reg_write, mem_to_reg, illegal, state, retire_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32
// subset (add, andi, bne, sh, lh) with a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC; on ready load IR and bump PC by 4
// DECODE | classify opcode, capture it into op_q; flag unsupported ops
// EXEC   | drive ALU; bne resolves here and retires
// MEM    | data access at ALU address; sh retires on ready
// WB     | register file write (ALU or memory data); retires
module multicycle_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_sequencer_if.master  bus
);
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ANDI = 7'b0010011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;
    localparam logic [6:0] OP_SH   = 7'b0100011;
    localparam logic [6:0] OP_LH   = 7'b0000011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_q, next_state;
    logic [6:0]          op_q;
    logic [RETIRE_W-1:0] retire_q;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src;
    logic       reg_write, mem_to_reg, illegal, retire;
    logic [3:0] alu_control;
    logic [3:0] op_alu_ctl;
    logic       op_alu_src;
    logic       supported;

    // ALU setup for the captured instruction; reused by EXEC, MEM and WB so
    // the address/result stays stable across the later states.
    always_comb begin
        op_alu_ctl = 4'b0000;
        op_alu_src = 1'b0;
        case (op_q)
            OP_ANDI: begin op_alu_ctl = 4'b0010; op_alu_src = 1'b1; end
            OP_BNE:  begin op_alu_ctl = 4'b1111; op_alu_src = 1'b0; end
            OP_SH,
            OP_LH:   begin op_alu_ctl = 4'b0000; op_alu_src = 1'b1; end
            default: begin op_alu_ctl = 4'b0000; op_alu_src = 1'b0; end
        endcase
    end

    assign supported = (bus.opcode == OP_ADD) || (bus.opcode == OP_ANDI) ||
                       (bus.opcode == OP_BNE) || (bus.opcode == OP_SH)   ||
                       (bus.opcode == OP_LH);

    // Next-state and control decode for the current state.
    always_comb begin
        next_state  = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src     = 1'b0;
        alu_control = 4'b0000;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (supported) begin
                    next_state = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_control = op_alu_ctl;
                alu_src     = op_alu_src;
                case (op_q)
                    OP_ADD, OP_ANDI: next_state = S_WB;
                    OP_SH, OP_LH:    next_state = S_MEM;
                    OP_BNE: begin
                        if (!bus.zero) begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                alu_control = op_alu_ctl;
                alu_src     = op_alu_src;
                mem_req     = 1'b1;
                iord        = 1'b1;
                mem_we      = (op_q == OP_SH);
                if (bus.mem_ready) begin
                    if (op_q == OP_SH) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_control = op_alu_ctl;
                alu_src     = op_alu_src;
                reg_write   = 1'b1;
                mem_to_reg  = (op_q == OP_LH);
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // State, captured opcode and retire counter; reset aborts any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= 7'd0;
            retire_q <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
            end
            if (retire) begin
                retire_q <= retire_q + RETIRE_W'(1);
            end
        end
    end

    // Controls are forced low while reset is held so an in-flight write or
    // request is dropped the moment reset asserts, not at the next edge.
    assign bus.mem_req      = mem_req    & ~reset;
    assign bus.mem_we       = mem_we     & ~reset;
    assign bus.iord         = iord       & ~reset;
    assign bus.ir_write     = ir_write   & ~reset;
    assign bus.pc_write     = pc_write   & ~reset;
    assign bus.pc_src       = pc_src     & ~reset;
    assign bus.alu_src      = alu_src    & ~reset;
    assign bus.alu_control  = alu_control & {4{~reset}};
    assign bus.reg_write    = reg_write  & ~reset;
    assign bus.mem_to_reg   = mem_to_reg & ~reset;
    assign bus.illegal      = illegal    & ~reset;
    assign bus.state        = state_q;
    assign bus.retire_count = retire_q;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32 subset datapath (add, andi, bne, sh, lh). It replaces per-instruction single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives PC, instruction register, ALU, register file and a shared single-port memory through a request/ready handshake. It sits between the memory port and the existing ALU/register-file datapath and counts retired instructions.

## Interface
- RETIRE_W, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- opcode  in  7  instruction[6:0] from instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag (rs1 - rs2 == 0)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (store), 0 = read
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
- alu_control  out  4  0000 add, 0010 and, 1111 compare (bne)
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU
- illegal  out  1  one-cycle pulse, unsupported opcode
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- retire_count  out  RETIRE_W  instructions completed, wraps modulo 2^RETIRE_W

## Operation
- State register plus op_q (7 b), captured from opcode at the DECODE edge. EXEC/MEM/WB decode op_q, never the live opcode.
- FETCH
  - mem_req=1, mem_we=0, iord=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0 (Mealy), next DECODE. Else stay.
- DECODE
  - All enables 0.
  - Supported op (0110011, 0010011, 1100011, 0100011, 0000011): next EXEC.
  - Otherwise: illegal=1 (Mealy, this cycle), next FETCH, no write of any kind.
- EXEC
  - 0110011: alu_control=0000, alu_src=0. Next WB.
  - 0010011: alu_control=0010, alu_src=1. Next WB.
  - 1100011: alu_control=1111, alu_src=0. If zero==0, pc_write=1 and pc_src=1. Next FETCH; retires.
  - 0100011 / 0000011: alu_control=0000, alu_src=1 (address). Next MEM.
- MEM
  - mem_req=1, iord=1, mem_we=1 for sh, 0 for lh.
  - alu_control/alu_src held as in EXEC so the address stays stable.
  - On mem_ready: sh goes to FETCH (retires); lh goes to WB. Else stay.
- WB
  - reg_write=1; mem_to_reg=1 for lh, 0 otherwise.
  - ALU controls held as in EXEC. Next FETCH; retires.
- retire_count increments by 1 on the cycle an instruction leaves its last state (bne EXEC, sh MEM with ready, WB). Illegal ops do not increment.
- Outputs not listed for a state are 0. alu_control=0000 in FETCH/DECODE.

## Timing
- Reset (async assert): state=FETCH, op_q=0, retire_count=0, all Moore outputs 0. In FETCH out of reset, mem_req=1 from the first cycle after deassertion.
- Reset mid-operation (e.g. in MEM with mem_we=1) aborts immediately. No reg_write, pc_write or retire occurs.
- Cycle counts with zero-wait memory (mem_ready=1 on first request cycle):
  - add/andi = 4 cycles
  - bne = 3 cycles
  - sh = 4 cycles
  - lh = 5 cycles
- Each cycle mem_ready is low in FETCH/MEM adds one cycle. Outputs stay constant while waiting.
- mem_ready outside FETCH/MEM is ignored.
- mem_req never drops before mem_ready; at most one request per FETCH/MEM visit.
- pc_write is asserted at most once per state visit. No state asserts both reg_write and mem_req.

## Test plan
- Reset asserted in MEM of sh (mem_ready=0): mem_req, mem_we, pc_write and reg_write go 0 immediately, state=0, retire_count=0; after release, first cycle has mem_req=1, iord=0.
- add (0110011), mem_ready=1 always: states 0,1,2,4,0. reg_write=1 only in WB with alu_control=0000, alu_src=0. retire_count 0->1.
- bne (1100011): zero=0 gives pc_write=1, pc_src=1 in EXEC. zero=1 gives pc_write=0 in EXEC. Both take 3 cycles and retire.
- lh (0000011) with mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_req=1, iord=1, mem_we=0, alu_control=0000 held. Then WB with reg_write=1, mem_to_reg=1. Total 7 cycles.
- sh (0100011): MEM has mem_we=1, iord=1, and reg_write is never asserted. Returns to FETCH after mem_ready and retires.
- Opcode 1111111: illegal pulses 1 cycle in DECODE, returns to FETCH, no reg_write/mem_req/pc_write, retire_count unchanged. Then run 2^RETIRE_W retiring andi ops and confirm retire_count wraps to 0.
